hud_score_writer: RTL and testbench



---
 rtl/hud_score_writer_pkg.sv | 37 +++
 rtl/hud_score_writer_if.sv | 28 ++
 rtl/hud_score_writer_bcd.sv | 38 +++
 rtl/hud_score_writer.sv | 179 +++++++++++++++++
 tb/tb_hud_score_writer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hud_score_writer_pkg.sv
// Shared FSM state type, field layout tables and saturation limits for the HUD score writer.
package hud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    EMIT,
    FINISH
  } state_t;

  localparam int NUM_FIELDS = 6;
  localparam int NUM_BLOBS  = 14;
  localparam int SCORE_MAX  = 9999;
  localparam int VAL_MAX    = 99;

  // Field 0 is the 4-digit score; fields 1..5 are 2-digit values packed after it.
  function automatic logic [3:0] field_base(input logic [2:0] f);
    case (f)
      3'd0:    field_base = 4'd0;
      3'd1:    field_base = 4'd4;
      3'd2:    field_base = 4'd6;
      3'd3:    field_base = 4'd8;
      3'd4:    field_base = 4'd10;
      default: field_base = 4'(NUM_BLOBS - 2);
    endcase
  endfunction

  function automatic logic [2:0] field_digits(input logic [2:0] f);
    return (f == 3'd0) ? 3'd4 : 3'd2;
  endfunction

  function automatic logic [3:0] field_shifts(input logic [2:0] f);
    return (f == 3'd0) ? 4'd14 : 4'd7;
  endfunction

endpackage

// File: rtl/hud_score_writer_if.sv
// Refresh request, snapshot inputs and digit-write port between the HUD feeder and its neighbours.
interface hud_score_writer_if #(
  parameter int SCORE_W = 14,
  parameter int VAL_W   = 7
);
  logic               refresh;
  logic [SCORE_W-1:0] score;
  logic [VAL_W-1:0]   val_a;
  logic [VAL_W-1:0]   val_b;
  logic [VAL_W-1:0]   val_c;
  logic [VAL_W-1:0]   val_d;
  logic [VAL_W-1:0]   val_e;
  logic               write;
  logic [3:0]         num;
  logic [3:0]         blob;
  logic               busy;
  logic               done;

  modport master (
    output refresh, score, val_a, val_b, val_c, val_d, val_e,
    input  write, num, blob, busy, done
  );

  modport slave (
    input  refresh, score, val_a, val_b, val_c, val_d, val_e,
    output write, num, blob, busy, done
  );
endinterface

// File: rtl/hud_score_writer_bcd.sv
// Serial shift-and-add-3 binary to 4-digit BCD converter; one step per enabled cycle.
// Binary operand is loaded MSB-aligned, so an N-bit value needs exactly N steps.
module bin2bcd_serial #(
  parameter int SCORE_W = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [SCORE_W-1:0] load_dat,
  output logic [15:0]        bcd
);

  localparam int SR_W = 16 + SCORE_W;

  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_adj;

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[SCORE_W + 4*i +: 4] >= 4'd5)
        sr_adj[SCORE_W + 4*i +: 4] = sr_q[SCORE_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sr_q <= '0;
    else if (load)
      sr_q <= {16'd0, load_dat};
    else if (step)
      sr_q <= sr_adj << 1;
  end

  assign bcd = sr_q[SR_W-1 -: 16];

endmodule

// File: rtl/hud_score_writer.sv
// Snapshots six HUD values on refresh, converts each to BCD and writes 14 digits; 70 cycles from refresh to done.
// No backpressure: refresh while busy is dropped, writes go out one per cycle in EMIT.
module hud_score_writer
  import hud_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int VAL_W   = 7
) (
  input logic              clk,
  input logic              reset_n,
  hud_score_writer_if.slave bus
);

  state_t             state_q, state_d;
  logic [2:0]         f_q, f_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         dig_q, dig_d;
  logic [VAL_W-1:0]   val_h [5];
  logic [VAL_W-1:0]   val_in [5];
  logic [VAL_W-1:0]   val_sat [5];
  logic [SCORE_W-1:0] score_sat;
  logic               snap;

  logic               write_q, write_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         num_q, num_d;
  logic [3:0]         blob_q, blob_d;

  logic               cv_load, cv_step;
  logic [SCORE_W-1:0] cv_dat;
  logic [15:0]        bcd;

  logic [2:0]         ndig;
  logic [3:0]         nshift;
  logic [3:0]         base;
  logic               last_step, last_dig, last_field;
  logic [1:0]         nib_sel;

  always_comb begin
    score_sat = (bus.score > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : bus.score;
    val_in[0] = bus.val_a;
    val_in[1] = bus.val_b;
    val_in[2] = bus.val_c;
    val_in[3] = bus.val_d;
    val_in[4] = bus.val_e;
    for (int i = 0; i < 5; i++)
      val_sat[i] = (val_in[i] > VAL_W'(VAL_MAX)) ? VAL_W'(VAL_MAX) : val_in[i];
  end

  // The converter is loaded on the edge entering LOAD and takes its first step on the
  // edge leaving it, so the final BCD is ready during the last SHIFT cycle and the first
  // digit can be registered straight into EMIT. The score therefore needs no holding register.
  always_comb begin
    ndig       = field_digits(f_q);
    nshift     = field_shifts(f_q);
    base       = field_base(f_q);
    last_step  = (cnt_q == nshift - 4'd1);
    last_dig   = ({1'b0, dig_q} == ndig - 3'd1);
    last_field = (f_q == 3'(NUM_FIELDS - 1));

    state_d = state_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    snap    = 1'b0;
    cv_load = 1'b0;
    cv_step = 1'b0;
    cv_dat  = score_sat;
    write_d = 1'b0;
    num_d   = num_q;
    blob_d  = blob_q;
    nib_sel = 2'(ndig - 3'd1);

    case (state_q)
      IDLE: begin
        if (bus.refresh) begin
          snap    = 1'b1;
          f_d     = 3'd0;
          cv_load = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = 4'd0;
        cv_step = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (last_step) begin
          state_d = EMIT;
          dig_d   = 2'd0;
          write_d = 1'b1;
          nib_sel = 2'(ndig - 3'd1);
          blob_d  = base;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          cv_step = 1'b1;
        end
      end
      EMIT: begin
        if (last_dig) begin
          if (last_field) begin
            state_d = FINISH;
          end else begin
            f_d     = f_q + 3'd1;
            cv_load = 1'b1;
            cv_dat  = {val_h[f_q], {(SCORE_W - VAL_W){1'b0}}};
            state_d = LOAD;
          end
        end else begin
          dig_d   = dig_q + 2'd1;
          write_d = 1'b1;
          nib_sel = 2'(ndig - 3'd2 - {1'b0, dig_q});
          blob_d  = base + 4'(dig_q) + 4'd1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (write_d)
      num_d = bcd[{nib_sel, 2'b00} +: 4];
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      f_q     <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      num_q   <= '0;
      blob_q  <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      num_q   <= num_d;
      blob_q  <= blob_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++)
        val_h[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < 5; i++)
        val_h[i] <= val_sat[i];
    end
  end

  bin2bcd_serial #(
    .SCORE_W (SCORE_W)
  ) u_bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cv_load),
    .step     (cv_step),
    .load_dat (cv_dat),
    .bcd      (bcd)
  );

  assign bus.write = write_q;
  assign bus.num   = num_q;
  assign bus.blob  = blob_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_hud_score_writer.sv
// Randomised and directed bench for hud_score_writer against a decimal-arithmetic reference model.
module tb_hud_score_writer;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  hud_score_writer_if #(.SCORE_W(14), .VAL_W(7)) bus ();

  hud_score_writer #(.SCORE_W(14), .VAL_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input int s, input int a, input int b, input int c, input int d, input int e);
    bus.score = 14'(s);
    bus.val_a = 7'(a);
    bus.val_b = 7'(b);
    bus.val_c = 7'(c);
    bus.val_d = 7'(d);
    bus.val_e = 7'(e);
  endtask

  function automatic int out_word();
    return int'({bus.write, bus.num, bus.blob, bus.busy, bus.done});
  endfunction

  // One refresh sequence. Observed writes are packed as cycle<<8 | blob<<4 | digit,
  // where cycle 1 is the cycle after the edge that samples refresh.
  task automatic do_seq(input int s, input int a, input int b, input int c, input int d, input int e,
                        input bit scramble, input bit rerefresh, input bit chain, input string tag);
    int exp_q[$];
    int got_q[$];
    int sv[6];
    int busy_n;
    int done_at;
    int t;
    int extra;
    int obs;
    sv[0] = (s > 9999) ? 9999 : s;
    sv[1] = (a > 99) ? 99 : a;
    sv[2] = (b > 99) ? 99 : b;
    sv[3] = (c > 99) ? 99 : c;
    sv[4] = (d > 99) ? 99 : d;
    sv[5] = (e > 99) ? 99 : e;
    t = 0;
    for (int f = 0; f < 6; f++) begin
      int nd;
      int base;
      nd   = (f == 0) ? 4 : 2;
      base = (f == 0) ? 0 : 2 + 2 * f;
      t    = t + 1 + ((f == 0) ? 14 : 7);
      for (int dd = 0; dd < nd; dd++) begin
        int p10;
        p10 = 1;
        repeat (nd - 1 - dd) p10 = p10 * 10;
        t++;
        exp_q.push_back((t << 8) | ((base + dd) << 4) | ((sv[f] / p10) % 10));
      end
    end

    @(negedge clk);
    set_inputs(s, a, b, c, d, e);
    bus.refresh = 1'b1;
    busy_n  = 0;
    done_at = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (i == 1) bus.refresh = 1'b0;
      if (scramble && i == 5)
        set_inputs($urandom_range(0, 16383), $urandom_range(0, 127), $urandom_range(0, 127),
                   $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
      if (rerefresh && i == 10) bus.refresh = 1'b1;
      if (rerefresh && i == 11) bus.refresh = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.write) got_q.push_back((i << 8) | (int'(bus.blob) << 4) | int'(bus.num));
      if (bus.done) begin
        done_at = i;
        break;
      end
    end

    check_val({tag, "_done_cycle"}, done_at, 70);
    check_val({tag, "_busy_cycles"}, busy_n, 70);
    check_val({tag, "_write_count"}, got_q.size(), 14);
    for (int j = 0; j < 14; j++) begin
      obs = (j < got_q.size()) ? got_q[j] : -1;
      check_val($sformatf("%s_wr%0d", tag, j), obs, exp_q[j]);
    end

    if (!chain) begin
      extra = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.write || bus.done || bus.busy) extra++;
      end
      check_val({tag, "_idle_after"}, extra, 0);
    end
  endtask

  task automatic do_reset_mid();
    int seen;
    @(negedge clk);
    set_inputs($urandom_range(0, 16383), $urandom_range(0, 127), $urandom_range(0, 127),
               $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    bus.refresh = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 1) bus.refresh = 1'b0;
    end
    // Cycle 33 lies inside the field-2 SHIFT window (cycles 31..37).
    check_val("rst_pre_busy", int'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    check_val("rst_outs_zero", out_word(), 0);
    repeat (2) @(negedge clk);
    check_val("rst_outs_held", out_word(), 0);
    reset_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.write || bus.done || bus.busy) seen++;
    end
    check_val("rst_no_resume", seen, 0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus.refresh = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("reset_outs", out_word(), 0);
    reset_n = 1'b1;

    do_seq(1234, 5, 42, 99, 0, 70, 1'b0, 1'b0, 1'b0, "basic");
    do_seq(16383, 127, 0, 1, 2, 3, 1'b0, 1'b0, 1'b0, "sat");
    do_seq(0, 0, 9, 10, 99, 0, 1'b0, 1'b0, 1'b0, "bnd0");
    do_seq(9, 9, 10, 99, 0, 9, 1'b0, 1'b0, 1'b0, "bnd9");
    do_seq(10, 10, 99, 0, 9, 10, 1'b0, 1'b0, 1'b0, "bnd10");
    do_seq(9999, 99, 0, 9, 10, 99, 1'b0, 1'b0, 1'b0, "bnd9999");
    do_seq(4321, 12, 34, 56, 78, 90, 1'b1, 1'b1, 1'b0, "snap");

    do_reset_mid();
    do_seq($urandom_range(0, 16383), $urandom_range(0, 127), $urandom_range(0, 127),
           $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
           1'b0, 1'b0, 1'b0, "after_rst");

    do_seq($urandom_range(0, 16383), $urandom_range(0, 127), $urandom_range(0, 127),
           $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
           1'b0, 1'b0, 1'b1, "b2b_a");
    do_seq($urandom_range(0, 16383), $urandom_range(0, 127), $urandom_range(0, 127),
           $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
           1'b0, 1'b0, 1'b0, "b2b_b");

    for (int n = 0; n < 16; n++)
      do_seq($urandom_range(0, 16383), $urandom_range(0, 127), $urandom_range(0, 127),
             $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
             1'b0, 1'b0, n[0], $sformatf("rnd%0d", n));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
